// File: rtl/keypad_input_unit.sv
// Keypad operand entry: scans a 4x4 matrix, debounces presses, collects up to three
// BCD digits plus sign and converts the entry to an 8-bit two's-complement operand.
module keypad_input_unit #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_TICKS = 10
) (
   input  logic        clock,
   input  logic        Reset,
   input  logic [3:0]  ROW,
   output logic [3:0]  COL,
   output logic [7:0]  EightBitNumber,
   output logic        Valid,
   output logic        Error,
   output logic        Neg,
   output logic [11:0] DigitsBCD,
   output logic [1:0]  DigitCount,
   output logic        key_evt_o,
   output logic        scan_state_o,
   output logic [1:0]  entry_state_o
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [3:0] K_SIGN  = 4'hA;
   localparam logic [3:0] K_CLEAR = 4'hE;
   localparam logic [3:0] K_ENTER = 4'hF;

   typedef enum logic {SCAN_RUN = 1'b0, SCAN_HOLD = 1'b1} scan_state_t;
   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ENTRY = 2'd1, ST_CHECK = 2'd2} entry_state_t;

   logic [3:0]       row_meta_q, row_sync_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;
   scan_state_t      scan_q, scan_d;
   logic [1:0]       col_q, col_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d, cnt_inc;
   logic [3:0]       cand_q, cand_d;
   logic             held;
   logic [1:0]       hit_row;
   // key_evt_q is a one-clock strobe qualifying key_code_q; there is no ready, the
   // entry FSM takes every strobe because strobes are many ticks apart.
   logic             key_evt_q, key_evt_d;
   logic [3:0]       key_code_q, key_code_d;

   entry_state_t     st_q, st_d;
   logic [11:0]      digits_q, digits_d;
   logic [1:0]       dcnt_q, dcnt_d;
   logic             neg_q, neg_d, err_q, err_d, valid_q, valid_d;
   logic [7:0]       num_q, num_d;
   logic [9:0]       mag;
   logic             is_digit, over_range;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'd1;    4'h1: k = 4'd2;  4'h2: k = 4'd3;    4'h3: k = K_SIGN;
         4'h4: k = 4'd4;    4'h5: k = 4'd5;  4'h6: k = 4'd6;    4'h7: k = 4'hB;
         4'h8: k = 4'd7;    4'h9: k = 4'd8;  4'hA: k = 4'd9;    4'hB: k = 4'hC;
         4'hC: k = K_CLEAR; 4'hD: k = 4'd0;  4'hE: k = K_ENTER; default: k = 4'hD;
      endcase
      return k;
   endfunction

   always_comb begin
      tick  = (div_q == DIV_W'(SCAN_DIV - 1));
      div_d = tick ? '0 : div_q + 1'b1;
      held  = (row_sync_q != 4'hF);
      hit_row = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!row_sync_q[i]) hit_row = 2'(i);
      end
   end

   // Scanner/debouncer next state: the column freezes while a key is seen.
   always_comb begin
      scan_d     = scan_q;
      col_d      = col_q;
      db_cnt_d   = db_cnt_q;
      cand_d     = cand_q;
      key_evt_d  = 1'b0;
      key_code_d = key_code_q;
      cnt_inc    = db_cnt_q + 1'b1;
      if (tick) begin
         case (scan_q)
            SCAN_RUN: begin
               if (held) begin
                  if (db_cnt_q != '0 && cand_q == {hit_row, col_q}) db_cnt_d = cnt_inc;
                  else                                              db_cnt_d = CNT_W'(1);
                  cand_d = {hit_row, col_q};
                  if (db_cnt_d == CNT_W'(DEBOUNCE_TICKS)) begin
                     key_evt_d  = 1'b1;
                     key_code_d = key_map(hit_row, col_q);
                     scan_d     = SCAN_HOLD;
                     db_cnt_d   = '0;
                  end
               end else begin
                  db_cnt_d = '0;
                  col_d    = col_q + 2'd1;
               end
            end
            SCAN_HOLD: begin
               if (held) db_cnt_d = '0;
               else if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) begin
                  scan_d   = SCAN_RUN;
                  db_cnt_d = '0;
               end else db_cnt_d = cnt_inc;
            end
            default: scan_d = SCAN_RUN;
         endcase
      end
   end

   always_comb begin
      COL          = ~(4'b0001 << col_q);
      key_evt_o    = key_evt_q;
      scan_state_o = scan_q;
   end

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
         div_q      <= '0;
         scan_q     <= SCAN_RUN;
         col_q      <= 2'd0;
         db_cnt_q   <= '0;
         cand_q     <= 4'd0;
         key_evt_q  <= 1'b0;
         key_code_q <= 4'd0;
      end else begin
         row_meta_q <= ROW;
         row_sync_q <= row_meta_q;
         div_q      <= div_d;
         scan_q     <= scan_d;
         col_q      <= col_d;
         db_cnt_q   <= db_cnt_d;
         cand_q     <= cand_d;
         key_evt_q  <= key_evt_d;
         key_code_q <= key_code_d;
      end
   end

   // Entry FSM: state and datapath registers.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         st_q     <= ST_EMPTY;
         digits_q <= 12'h000;
         dcnt_q   <= 2'd0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         num_q    <= 8'h00;
      end else begin
         st_q     <= st_d;
         digits_q <= digits_d;
         dcnt_q   <= dcnt_d;
         neg_q    <= neg_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         num_q    <= num_d;
      end
   end

   always_comb begin
      is_digit   = (key_code_q <= 4'd9);
      mag        = 10'(digits_q[11:8]) * 10'd100 + 10'(digits_q[7:4]) * 10'd10 + 10'(digits_q[3:0]);
      over_range = (!neg_q && mag > 10'd127) || (neg_q && mag > 10'd128);
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_EMPTY: if (key_evt_q && is_digit) st_d = ST_ENTRY;
         ST_ENTRY: begin
            if (key_evt_q && key_code_q == K_ENTER)      st_d = ST_CHECK;
            else if (key_evt_q && key_code_q == K_CLEAR) st_d = ST_EMPTY;
         end
         default:  st_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      digits_d = digits_q;
      dcnt_d   = dcnt_q;
      neg_d    = neg_q;
      err_d    = err_q;
      num_d    = num_q;
      valid_d  = 1'b0;
      case (st_q)
         ST_EMPTY, ST_ENTRY: begin
            if (key_evt_q) begin
               if (is_digit) begin
                  if (st_q == ST_EMPTY) begin
                     digits_d = {8'h00, key_code_q};
                     dcnt_d   = 2'd1;
                     err_d    = 1'b0;
                  end else if (dcnt_q != 2'd3) begin
                     digits_d = {digits_q[7:0], key_code_q};
                     dcnt_d   = dcnt_q + 2'd1;
                  end
               end else if (key_code_q == K_SIGN) begin
                  neg_d = ~neg_q;
               end else if (key_code_q == K_CLEAR) begin
                  digits_d = 12'h000;
                  dcnt_d   = 2'd0;
                  neg_d    = 1'b0;
                  err_d    = 1'b0;
               end
            end
         end
         ST_CHECK: begin
            if (over_range) err_d = 1'b1;
            else begin
               num_d   = neg_q ? 8'd0 - mag[7:0] : mag[7:0];
               valid_d = 1'b1;
            end
            digits_d = 12'h000;
            dcnt_d   = 2'd0;
            neg_d    = 1'b0;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      EightBitNumber = num_q;
      Valid          = valid_q;
      Error          = err_q;
      Neg            = neg_q;
      DigitsBCD      = digits_q;
      DigitCount     = dcnt_q;
      entry_state_o  = st_q;
   end

endmodule

// File: tb/tb_keypad_input_unit.sv
// Bench for keypad_input_unit: a behavioural keypad drives ROW from COL and a
// digit-list model of the calculator entry predicts every visible output.
module tb_keypad_input_unit;

   localparam int SCAN_DIV  = 4;
   localparam int DEB       = 2;
   localparam int HOLD_CLKS = 48;
   localparam int REL_CLKS  = 48;

   logic        clk, rst_n;
   logic [3:0]  row, col;
   logic [7:0]  num;
   logic        valid, err, neg;
   logic [11:0] bcd;
   logic [1:0]  dcnt;
   logic        key_evt;
   logic        scan_st;
   logic [1:0]  entry_st;

   logic        key_down;
   logic [1:0]  key_r, key_c;

   int checks = 0;
   int errors = 0;

   int         m_digits[$];
   bit         m_neg, m_err, m_entry, exp_valid;
   logic [7:0] m_num;

   int         obs_cyc, obs_evt, obs_valid, obs_evt_idx, obs_valid_idx;
   logic [7:0] obs_valid_num;

   keypad_input_unit #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DEB)) dut (
      .clock(clk), .Reset(rst_n), .ROW(row), .COL(col),
      .EightBitNumber(num), .Valid(valid), .Error(err), .Neg(neg),
      .DigitsBCD(bcd), .DigitCount(dcnt), .key_evt_o(key_evt),
      .scan_state_o(scan_st), .entry_state_o(entry_st)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad: a held key pulls its row low only while its column is driven low.
   always_comb begin
      row = 4'hF;
      if (key_down && col[key_c] == 1'b0) row[key_r] = 1'b0;
   end

   // ---------------- reference model ----------------
   task automatic model_reset();
      m_digits = {};
      m_neg    = 1'b0;
      m_err    = 1'b0;
      m_entry  = 1'b0;
      m_num    = 8'h00;
   endtask

   function automatic logic [11:0] model_bcd();
      logic [11:0] v = 12'h000;
      foreach (m_digits[i]) v = (v << 4) | 12'(m_digits[i]);
      return v;
   endfunction

   task automatic model_key(input byte ch);
      int mag;
      exp_valid = 1'b0;
      if (ch >= "0" && ch <= "9") begin
         if (!m_entry) begin
            m_digits = {};
            m_digits.push_back(ch - 48);
            m_err    = 1'b0;
            m_entry  = 1'b1;
         end else if (m_digits.size() < 3) begin
            m_digits.push_back(ch - 48);
         end
      end else if (ch == "A") begin
         m_neg = !m_neg;
      end else if (ch == "*") begin
         m_digits = {};
         m_neg    = 1'b0;
         m_err    = 1'b0;
         m_entry  = 1'b0;
      end else if (ch == "#" && m_entry) begin
         mag = 0;
         foreach (m_digits[i]) mag = mag * 10 + m_digits[i];
         if ((!m_neg && mag > 127) || (m_neg && mag > 128)) m_err = 1'b1;
         else begin
            m_num     = m_neg ? 8'((256 - mag) % 256) : 8'(mag);
            exp_valid = 1'b1;
         end
         m_digits = {};
         m_neg    = 1'b0;
         m_entry  = 1'b0;
      end
   endtask

   // ---------------- driver ----------------
   task automatic step();
      @(negedge clk);
      obs_cyc++;
      if (key_evt === 1'b1) begin
         obs_evt++;
         obs_evt_idx = obs_cyc;
      end
      if (valid === 1'b1) begin
         obs_valid++;
         obs_valid_idx = obs_cyc;
         obs_valid_num = num;
      end
   endtask

   task automatic press(input byte ch, input int bounces);
      string layout;
      int    idx;
      layout = "123A456B789C*0#D";
      idx = 0;
      for (int i = 0; i < 16; i++) if (layout[i] == ch) idx = i;
      key_r = 2'(idx / 4);
      key_c = 2'(idx % 4);
      obs_cyc = 0; obs_evt = 0; obs_valid = 0; obs_evt_idx = -1; obs_valid_idx = -1;
      for (int b = 0; b < bounces; b++) begin
         key_down = 1'b1;
         repeat (SCAN_DIV) step();
         key_down = 1'b0;
         repeat (SCAN_DIV) step();
      end
      key_down = 1'b1;
      repeat (HOLD_CLKS) step();
      key_down = 1'b0;
      repeat (REL_CLKS) step();
      model_key(ch);

      checks++;
      if (obs_evt !== 1) begin
         errors++; $display("FAIL key_evt_count key %c: got %0d expected 1", ch, obs_evt);
      end
      checks++;
      if (obs_valid !== int'(exp_valid)) begin
         errors++; $display("FAIL valid_pulses key %c: got %0d expected %0d", ch, obs_valid, exp_valid);
      end
      if (exp_valid && obs_valid == 1) begin
         checks++;
         if (obs_valid_num !== m_num) begin
            errors++; $display("FAIL valid_number: got %h expected %h", obs_valid_num, m_num);
         end
         checks++;
         if (obs_valid_idx != obs_evt_idx + 2) begin
            errors++; $display("FAIL enter_latency: valid at %0d expected %0d", obs_valid_idx, obs_evt_idx + 2);
         end
      end
      checks++;
      if (bcd !== model_bcd()) begin
         errors++; $display("FAIL digits_bcd key %c: got %h expected %h", ch, bcd, model_bcd());
      end
      checks++;
      if (dcnt !== 2'(m_digits.size())) begin
         errors++; $display("FAIL digit_count key %c: got %0d expected %0d", ch, dcnt, m_digits.size());
      end
      checks++;
      if (neg !== m_neg || err !== m_err) begin
         errors++; $display("FAIL neg_error key %c: got %b%b expected %b%b", ch, neg, err, m_neg, m_err);
      end
      checks++;
      if (num !== m_num) begin
         errors++; $display("FAIL number_hold key %c: got %h expected %h", ch, num, m_num);
      end
      checks++;
      if (!(col inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) begin
         errors++; $display("FAIL col_one_low: got %b", col);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      key_down = 1'b0; key_r = 2'd0; key_c = 2'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (col !== 4'b1110 || num !== 8'h00 || valid !== 1'b0 || err !== 1'b0 || neg !== 1'b0 ||
          bcd !== 12'h000 || dcnt !== 2'd0 || key_evt !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: col=%b num=%h v=%b e=%b n=%b bcd=%h cnt=%0d evt=%b",
                  col, num, valid, err, neg, bcd, dcnt, key_evt);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_basic_entry();
      press("1", 0); press("2", 0); press("7", 0);
      checks++;
      if (bcd !== 12'h127) begin errors++; $display("FAIL entry_127: got %h expected 127", bcd); end
      press("#", 0);
      checks++;
      if (num !== 8'h7F || err !== 1'b0 || neg !== 1'b0) begin
         errors++; $display("FAIL result_127: got %h e=%b n=%b expected 7f 0 0", num, err, neg);
      end
   endtask

   task automatic test_negative();
      press("A", 0);
      checks++;
      if (neg !== 1'b1) begin errors++; $display("FAIL sign_toggle: got %b expected 1", neg); end
      press("1", 0); press("2", 0); press("8", 0);
      press("#", 0);
      checks++;
      if (num !== 8'h80) begin errors++; $display("FAIL result_m128: got %h expected 80", num); end
   endtask

   task automatic test_range_error();
      press("1", 0); press("2", 0); press("8", 0); press("#", 0);
      checks++;
      if (err !== 1'b1 || num !== 8'h80) begin
         errors++; $display("FAIL range_error: got e=%b num=%h expected 1 80", err, num);
      end
      press("5", 0);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL error_clear_on_digit: got %b expected 0", err); end
      press("*", 0);
   endtask

   task automatic test_overflow_clear();
      press("4", 0); press("5", 0); press("6", 0); press("9", 0);
      checks++;
      if (bcd !== 12'h456 || dcnt !== 2'd3) begin
         errors++; $display("FAIL fourth_digit: got %h/%0d expected 456/3", bcd, dcnt);
      end
      press("A", 0); press("*", 0);
      checks++;
      if (bcd !== 12'h000 || dcnt !== 2'd0 || neg !== 1'b0) begin
         errors++; $display("FAIL clear: got %h/%0d/%b expected 000/0/0", bcd, dcnt, neg);
      end
   endtask

   task automatic test_edges();
      press("A", 0); press("0", 0); press("#", 0);
      checks++;
      if (num !== 8'h00) begin errors++; $display("FAIL minus_zero: got %h expected 00", num); end
      press("0", 0); press("0", 0); press("7", 0); press("#", 0);
      checks++;
      if (num !== 8'h07) begin errors++; $display("FAIL leading_zeros: got %h expected 07", num); end
      press("#", 0); press("B", 0); press("C", 0); press("D", 0);
      press("A", 0); press("1", 0); press("2", 0); press("9", 0); press("#", 0);
      checks++;
      if (err !== 1'b1 || num !== 8'h07) begin
         errors++; $display("FAIL minus_129: got e=%b num=%h expected 1 07", err, num);
      end
      press("*", 0);
   endtask

   task automatic test_bounce();
      press("5", 3);
      checks++;
      if (bcd !== 12'h005) begin errors++; $display("FAIL bounce_digit: got %h expected 005", bcd); end
      press("*", 0);
   endtask

   task automatic test_mid_reset();
      int n;
      press("3", 0);
      key_down = 1'b0; key_r = 2'd2; key_c = 2'd2;
      n = 0;
      while (col !== 4'b1101 && n < 64) begin @(negedge clk); n++; end
      key_down = 1'b1;
      while (col !== 4'b1011 && n < 128) begin @(negedge clk); n++; end
      checks++;
      if (n >= 64) begin errors++; $display("FAIL scan_timeout: waited %0d cycles, limit 64", n); end
      obs_evt = 0;
      repeat (6) step();
      checks++;
      if (obs_evt !== 0) begin errors++; $display("FAIL early_event: got %0d expected 0", obs_evt); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (col !== 4'b1110 || num !== 8'h00 || valid !== 1'b0 || err !== 1'b0 || neg !== 1'b0 ||
          bcd !== 12'h000 || dcnt !== 2'd0 || key_evt !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_values: col=%b num=%h v=%b e=%b n=%b bcd=%h cnt=%0d evt=%b",
                  col, num, valid, err, neg, bcd, dcnt, key_evt);
      end
      key_down = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      obs_evt = 0;
      repeat (REL_CLKS) step();
      checks++;
      if (obs_evt !== 0 || bcd !== 12'h000 || dcnt !== 2'd0) begin
         errors++; $display("FAIL post_reset_idle: evt=%0d bcd=%h cnt=%0d expected 0 000 0", obs_evt, bcd, dcnt);
      end
   endtask

   task automatic test_random();
      string keys;
      keys = "0123456789A##*BCD";
      for (int k = 0; k < 40; k++) press(keys[$urandom_range(0, 16)], $urandom_range(0, 1));
   endtask

   initial begin
      test_reset();
      test_basic_entry();
      test_negative();
      test_range_error();
      test_overflow_clear();
      test_edges();
      test_bounce();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
